// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF-stage program-counter unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  localparam int INST_BYTES_DEFAULT = 4;
  localparam int ALIGN_LSB = $clog2(INST_BYTES_DEFAULT);

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux with redirect-target alignment mask and flag.
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int INST_BYTES  = INST_BYTES_DEFAULT,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  state_e            i_state,
  input  logic [XLEN-1:0]   i_pc,
  input  logic              i_stall,
  input  logic              i_imem_ready,
  input  logic              i_halt,
  input  logic              i_redirect_valid,
  input  logic [XLEN-1:0]   i_redirect_pc,
  input  logic              i_trap_valid,
  input  logic [XLEN-1:0]   i_trap_pc,
  output logic [XLEN-1:0]   o_next_pc,
  output logic [XLEN-1:0]   o_pc_seq,
  output logic              o_misaligned
);

  logic [XLEN-1:0] w_step;
  logic [XLEN-1:0] w_mask;
  logic [XLEN-1:0] w_tgt;
  logic [XLEN-1:0] w_tgt_al;
  logic            w_load;
  logic            w_bad;
  logic            w_hold;

  assign w_step   = XLEN'(INST_BYTES);
  assign w_mask   = ~(w_step - 1'b1);
  assign o_pc_seq = i_pc + w_step;

  // Halting freezes the sequential step so the
  // held PC is re-fetched after resume.
  assign w_hold = i_stall | ~i_imem_ready | i_halt;

  always_comb begin
    w_tgt  = '0;
    w_load = 1'b0;
    unique case (i_state)
      S_RUN: begin
        if (i_trap_valid) begin
          w_tgt  = i_trap_pc;
          w_load = 1'b1;
        end else if (i_redirect_valid) begin
          w_tgt  = i_redirect_pc;
          w_load = 1'b1;
        end
      end
      S_HALT: begin
        if (i_trap_valid) begin
          w_tgt  = i_trap_pc;
          w_load = 1'b1;
        end
      end
      default: begin
        w_tgt  = '0;
        w_load = 1'b0;
      end
    endcase
  end

  assign w_tgt_al = ALIGN_CHECK ? (w_tgt & w_mask) : w_tgt;
  assign w_bad    = |(w_tgt & ~w_mask);

  always_comb begin
    o_next_pc = i_pc;
    if (w_load) begin
      o_next_pc = w_tgt_al;
    end else if (i_state == S_RUN && !w_hold) begin
      o_next_pc = o_pc_seq;
    end
  end

  assign o_misaligned = w_load & ALIGN_CHECK & w_bad;

endmodule

// File: rtl/pc_fetch_unit.sv
// IF-stage program counter: PC register, misalignment flag
// register and BOOT/RUN/HALT fetch FSM.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INST_BYTES   = INST_BYTES_DEFAULT,
  parameter bit              ALIGN_CHECK  = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            imem_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            halt,
  input  logic            resume,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_next_seq,
  output logic            fetch_valid,
  output logic            misaligned,
  output logic            halted
);

  state_e          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_mis;
  logic [XLEN-1:0] w_next_pc;
  logic            w_mis;

  pc_next_sel #(
    .XLEN        (XLEN),
    .INST_BYTES  (INST_BYTES),
    .ALIGN_CHECK (ALIGN_CHECK)
  ) u_sel (
    .i_state          (r_state),
    .i_pc             (r_pc),
    .i_stall          (stall),
    .i_imem_ready     (imem_ready),
    .i_halt           (halt),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_trap_valid     (trap_valid),
    .i_trap_pc        (trap_pc),
    .o_next_pc        (w_next_pc),
    .o_pc_seq         (pc_next_seq),
    .o_misaligned     (w_mis)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_VECTOR;
      r_mis   <= 1'b0;
    end else begin
      r_pc  <= w_next_pc;
      r_mis <= w_mis;
      unique case (r_state)
        S_BOOT: r_state <= S_RUN;
        S_RUN: begin
          if (halt) r_state <= S_HALT;
        end
        S_HALT: begin
          if (trap_valid || resume) r_state <= S_RUN;
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign pc_out      = r_pc;
  assign misaligned  = r_mis;
  assign fetch_valid = (r_state == S_RUN);
  assign halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        imem_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        halt;
  logic        resume;
  logic [31:0] pc_out;
  logic [31:0] pc_next_seq;
  logic        fetch_valid;
  logic        misaligned;
  logic        halted;
  logic [31:0] na_pc_out;
  logic [31:0] na_pc_next_seq;
  logic        na_fetch_valid;
  logic        na_misaligned;
  logic        na_halted;

  int checks = 0;
  int passed = 0;

  pc_fetch_unit #(
    .XLEN (32), .RESET_VECTOR (32'h0),
    .INST_BYTES (4), .ALIGN_CHECK (1'b1)
  ) dut (
    .clk (clk), .reset (reset), .stall (stall),
    .imem_ready (imem_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc (redirect_pc),
    .trap_valid (trap_valid), .trap_pc (trap_pc),
    .halt (halt), .resume (resume),
    .pc_out (pc_out), .pc_next_seq (pc_next_seq),
    .fetch_valid (fetch_valid),
    .misaligned (misaligned), .halted (halted)
  );

  pc_fetch_unit #(
    .XLEN (32), .RESET_VECTOR (32'h0),
    .INST_BYTES (4), .ALIGN_CHECK (1'b0)
  ) dut_na (
    .clk (clk), .reset (reset), .stall (stall),
    .imem_ready (imem_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc (redirect_pc),
    .trap_valid (trap_valid), .trap_pc (trap_pc),
    .halt (halt), .resume (resume),
    .pc_out (na_pc_out), .pc_next_seq (na_pc_next_seq),
    .fetch_valid (na_fetch_valid),
    .misaligned (na_misaligned), .halted (na_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; imem_ready = 1;
    redirect_valid = 0; redirect_pc = '0;
    trap_valid = 0; trap_pc = '0;
    halt = 0; resume = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    step();
    checks++;
    if ({pc_out, fetch_valid, misaligned, halted} !== {32'h0, 3'b000})
      $display("FAIL reset_state pc=%h fv=%b mis=%b h=%b want 0/0/0/0",
               pc_out, fetch_valid, misaligned, halted);
    else passed++;
    reset = 0;
    step();
    checks++;
    if (pc_out !== 32'h0 || fetch_valid !== 1'b1)
      $display("FAIL boot_exit pc=%h fv=%b want 0/1", pc_out, fetch_valid);
    else passed++;
    step();
    checks++;
    if (pc_out !== 32'h4)
      $display("FAIL run_inc1 pc=%h want 4", pc_out);
    else passed++;
    step();
    checks++;
    if (pc_out !== 32'h8)
      $display("FAIL run_inc2 pc=%h want 8", pc_out);
    else passed++;
  endtask

  task automatic test_stall();
    stall = 1;
    step();
    checks++;
    if (pc_out !== 32'h8)
      $display("FAIL stall1 pc=%h want 8", pc_out);
    else passed++;
    step();
    checks++;
    if (pc_out !== 32'h8)
      $display("FAIL stall2 pc=%h want 8", pc_out);
    else passed++;
    stall = 0; imem_ready = 0;
    step();
    checks++;
    if (pc_out !== 32'h8)
      $display("FAIL backpressure pc=%h want 8", pc_out);
    else passed++;
    imem_ready = 1;
    step();
    checks++;
    if (pc_out !== 32'hC)
      $display("FAIL after_stall pc=%h want c", pc_out);
    else passed++;
  endtask

  task automatic test_redirect();
    stall = 1; redirect_valid = 1; redirect_pc = 32'h100;
    step();
    checks++;
    if (pc_out !== 32'h100)
      $display("FAIL redirect_over_stall pc=%h want 100", pc_out);
    else passed++;
    stall = 0; redirect_pc = 32'h200;
    trap_valid = 1; trap_pc = 32'h80;
    step();
    checks++;
    if (pc_out !== 32'h80 || pc_next_seq !== 32'h84)
      $display("FAIL trap_priority pc=%h seq=%h want 80/84",
               pc_out, pc_next_seq);
    else passed++;
    idle_inputs();
  endtask

  task automatic test_misalign();
    redirect_valid = 1; redirect_pc = 32'h102;
    step();
    checks++;
    if (pc_out !== 32'h100 || misaligned !== 1'b1)
      $display("FAIL misalign_load pc=%h mis=%b want 100/1",
               pc_out, misaligned);
    else passed++;
    checks++;
    if (na_pc_out !== 32'h102 || na_misaligned !== 1'b0)
      $display("FAIL noalign_load pc=%h mis=%b want 102/0",
               na_pc_out, na_misaligned);
    else passed++;
    redirect_valid = 0; stall = 1;
    step();
    checks++;
    if (pc_out !== 32'h100 || misaligned !== 1'b0)
      $display("FAIL misalign_pulse pc=%h mis=%b want 100/0",
               pc_out, misaligned);
    else passed++;
    stall = 0;
  endtask

  task automatic test_halt();
    redirect_valid = 1; redirect_pc = 32'h20;
    step();
    redirect_valid = 0; halt = 1;
    step();
    checks++;
    if (halted !== 1'b1 || fetch_valid !== 1'b0 || pc_out !== 32'h20)
      $display("FAIL halt_enter h=%b fv=%b pc=%h want 1/0/20",
               halted, fetch_valid, pc_out);
    else passed++;
    halt = 0; redirect_valid = 1; redirect_pc = 32'h300;
    step();
    checks++;
    if (halted !== 1'b1 || pc_out !== 32'h20)
      $display("FAIL halt_ignore_redirect h=%b pc=%h want 1/20",
               halted, pc_out);
    else passed++;
    redirect_valid = 0; resume = 1;
    step();
    checks++;
    if (halted !== 1'b0 || fetch_valid !== 1'b1 || pc_out !== 32'h20)
      $display("FAIL resume h=%b fv=%b pc=%h want 0/1/20",
               halted, fetch_valid, pc_out);
    else passed++;
    resume = 0;
    step();
    checks++;
    if (pc_out !== 32'h24)
      $display("FAIL resume_inc pc=%h want 24", pc_out);
    else passed++;
    halt = 1;
    step();
    halt = 0; resume = 1; trap_valid = 1; trap_pc = 32'h80;
    step();
    checks++;
    if (fetch_valid !== 1'b1 || halted !== 1'b0 || pc_out !== 32'h80)
      $display("FAIL halt_trap fv=%b h=%b pc=%h want 1/0/80",
               fetch_valid, halted, pc_out);
    else passed++;
    idle_inputs();
    halt = 1; redirect_valid = 1; redirect_pc = 32'h40;
    step();
    checks++;
    if (halted !== 1'b1 || pc_out !== 32'h40)
      $display("FAIL halt_with_redirect h=%b pc=%h want 1/40",
               halted, pc_out);
    else passed++;
    idle_inputs();
    resume = 1;
    step();
    resume = 0;
  endtask

  task automatic test_wrap_reset();
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    step();
    checks++;
    if (pc_out !== 32'hFFFF_FFFC || pc_next_seq !== 32'h0)
      $display("FAIL wrap_seq pc=%h seq=%h want fffffffc/0",
               pc_out, pc_next_seq);
    else passed++;
    redirect_valid = 0;
    step();
    checks++;
    if (pc_out !== 32'h0 || misaligned !== 1'b0)
      $display("FAIL wrap pc=%h mis=%b want 0/0", pc_out, misaligned);
    else passed++;
    step();
    halt = 1;
    step();
    halt = 0; reset = 1;
    redirect_valid = 1; redirect_pc = 32'h500;
    step();
    checks++;
    if (pc_out !== 32'h0 || halted !== 1'b0 || fetch_valid !== 1'b0)
      $display("FAIL reset_in_halt pc=%h h=%b fv=%b want 0/0/0",
               pc_out, halted, fetch_valid);
    else passed++;
    idle_inputs(); reset = 0;
    step();
    step();
    stall = 1;
    step();
    reset = 1; trap_valid = 1; trap_pc = 32'h80;
    step();
    checks++;
    if (pc_out !== 32'h0 || fetch_valid !== 1'b0 || halted !== 1'b0)
      $display("FAIL reset_in_stall pc=%h fv=%b h=%b want 0/0/0",
               pc_out, fetch_valid, halted);
    else passed++;
    idle_inputs(); reset = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_stall();
    test_redirect();
    test_misalign();
    test_halt();
    test_wrap_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
